fetch_decode: RTL and testbench

Instruction fetch/decode controller that sits on the consuming side of the program counter. It takes the instruction word read from program ROM at the address the counter presents, and issues ordinary instructions to the datapath. It decodes control-flow opcodes and drives the counter's `jsr`, `ret`, `preload`, `preload_addr` and `relative_addr` inputs as single-cycle pulses. It also tracks the single-level call depth, enforces the two-word delay-slot architecture, and flags illegal sequences.

---
 rtl/fetch_decode_if.sv | 28 ++
 rtl/fetch_decode.sv | 135 +++++++++++++
 tb/tb_fetch_decode.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Port bundle between the fetch/decode controller and its program counter, ROM and datapath.
interface fetch_decode_if;
  logic        boot_addr_sel;
  logic [10:0] boot_addr;
  logic [10:0] pc;
  logic [15:0] instr;
  logic        jsr;
  logic        ret;
  logic        preload;
  logic [10:0] preload_addr;
  logic [9:0]  relative_addr;
  logic [15:0] ir;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic [3:0]  err;

  modport master (
    input  boot_addr_sel, boot_addr, pc, instr,
    output jsr, ret, preload, preload_addr, relative_addr,
    output ir, ir_valid, ir_pc, err
  );

  modport slave (
    output boot_addr_sel, boot_addr, pc, instr,
    input  jsr, ret, preload, preload_addr, relative_addr,
    input  ir, ir_valid, ir_pc, err
  );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode controller: issues ordinary words, turns JSR/RET/JMP into counter pulses,
// tracks single-level call depth and the two-word delay slots, and keeps sticky error flags.
module fetch_decode #(
  parameter logic [10:0] BOOT_DEFAULT = 11'd0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_decode_if.master bus
);

  typedef enum logic [1:0] {BOOT, FILL, RUN} state_t;

  state_t      state, state_n;
  logic [1:0]  slot, slot_n;
  logic        depth, depth_n;
  logic [10:0] pc_d;

  logic        jsr_n, ret_n, pre_n, vld_n;
  logic [10:0] pa_n, irpc_n;
  logic [9:0]  ra_n;
  logic [15:0] ir_n;
  logic [3:0]  err_n;

  logic [3:0]  op;
  logic [9:0]  rel;
  logic        is_jsr, is_ret, is_jmp, is_ctrl;

  assign op      = bus.instr[15:12];
  assign rel     = bus.instr[9:0];
  assign is_jsr  = (op == 4'hF);
  assign is_ret  = (op == 4'hE);
  assign is_jmp  = (op == 4'hD);
  assign is_ctrl = is_jsr | is_ret | is_jmp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    depth_n = depth;
    jsr_n   = 1'b0;
    ret_n   = 1'b0;
    pre_n   = 1'b0;
    vld_n   = 1'b0;
    pa_n    = bus.preload_addr;
    ra_n    = bus.relative_addr;
    ir_n    = bus.ir;
    irpc_n  = bus.ir_pc;
    err_n   = bus.err;
    case (state)
      BOOT: begin
        state_n = FILL;
        pre_n   = 1'b1;
        pa_n    = bus.boot_addr_sel ? bus.boot_addr : BOOT_DEFAULT;
        slot_n  = 2'd2;
      end
      FILL: begin
        // words already in flight from before the boot preload are squashed
        if (slot != 2'd0) slot_n = slot - 2'd1;
        if (slot <= 2'd1) state_n = RUN;
      end
      RUN: begin
        if (slot != 2'd0) begin
          slot_n = slot - 2'd1;
          if (is_ctrl) err_n[3] = 1'b1;
          else begin
            vld_n  = 1'b1;
            ir_n   = bus.instr;
            irpc_n = pc_d;
          end
        end else if (is_jmp) begin
          pre_n  = 1'b1;
          pa_n   = bus.instr[10:0];
          slot_n = 2'd2;
        end else if (is_jsr) begin
          if (depth)              err_n[0] = 1'b1;
          else if (rel < 10'd2)   err_n[2] = 1'b1;
          else begin
            // counter already points two past the JSR when it samples the pulse
            jsr_n   = 1'b1;
            ra_n    = rel - 10'd2;
            depth_n = 1'b1;
            slot_n  = 2'd2;
          end
        end else if (is_ret) begin
          if (!depth) err_n[1] = 1'b1;
          else begin
            ret_n   = 1'b1;
            depth_n = 1'b0;
            slot_n  = 2'd2;
          end
        end else begin
          vld_n  = 1'b1;
          ir_n   = bus.instr;
          irpc_n = pc_d;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot              <= 2'd0;
      depth             <= 1'b0;
      pc_d              <= 11'd0;
      bus.jsr           <= 1'b0;
      bus.ret           <= 1'b0;
      bus.preload       <= 1'b0;
      bus.preload_addr  <= 11'd0;
      bus.relative_addr <= 10'd0;
      bus.ir            <= 16'd0;
      bus.ir_valid      <= 1'b0;
      bus.ir_pc         <= 11'd0;
      bus.err           <= 4'd0;
    end else begin
      slot              <= slot_n;
      depth             <= depth_n;
      pc_d              <= bus.pc;
      bus.jsr           <= jsr_n;
      bus.ret           <= ret_n;
      bus.preload       <= pre_n;
      bus.preload_addr  <= pa_n;
      bus.relative_addr <= ra_n;
      bus.ir            <= ir_n;
      bus.ir_valid      <= vld_n;
      bus.ir_pc         <= irpc_n;
      bus.err           <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a program counter + synchronous ROM environment, a directed
// expectation table, and a random program checked against an instruction-level ISA model.
module tb_fetch_decode;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_decode_if bus ();
  fetch_decode #(.BOOT_DEFAULT(11'h010)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [15:0] rom [2048];
  logic [10:0] saved;

  // program counter with one-level return register, and 1-cycle ROM
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pc    <= 11'd0;
      saved     <= 11'd0;
      bus.instr <= 16'd0;
    end else begin
      bus.instr <= rom[bus.pc];
      if (bus.preload)  bus.pc <= bus.preload_addr;
      else if (bus.jsr) begin
        saved  <= bus.pc;
        bus.pc <= bus.pc + {1'b0, bus.relative_addr};
      end
      else if (bus.ret) bus.pc <= saved + 11'd1;
      else              bus.pc <= bus.pc + 11'd1;
    end
  end

  typedef struct {
    logic        v;
    logic [15:0] ir;
    logic [10:0] ip;
    logic        j, r, p;
    logic [10:0] pa;
    logic [9:0]  ra;
    logic [3:0]  e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] pk(logic v, logic [15:0] ir, logic [10:0] ip, logic j, logic r,
                                     logic p, logic [10:0] pa, logic [9:0] ra, logic [3:0] e);
    return {8'h00, v, (v ? ir : 16'h0), (v ? ip : 11'h0), j, r, p,
            (p ? pa : 11'h0), (j ? ra : 10'h0), e};
  endfunction

  function automatic logic [63:0] dut_pk();
    return pk(bus.ir_valid, bus.ir, bus.ir_pc, bus.jsr, bus.ret, bus.preload,
              bus.preload_addr, bus.relative_addr, bus.err);
  endfunction

  function automatic logic [63:0] vec_pk(vec_t t);
    return pk(t.v, t.ir, t.ip, t.j, t.r, t.p, t.pa, t.ra, t.e);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  vec_t tbl [21];

  initial begin
    logic [10:0] m_pc, m_tgt, m_retto, t, epa;
    logic [9:0]  era;
    logic [15:0] w;
    logic [3:0]  op, m_err;
    logic        m_depth, m_pend, taken, ctrl, ev, ej, er, ep;
    int          m_slots;

    tbl[0]  = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b1, 11'h010, 10'h0,   4'h0};
    tbl[1]  = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[2]  = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[3]  = '{1'b1, 16'h1234, 11'h010, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[4]  = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b1, 11'h020, 10'h0,   4'h0};
    tbl[5]  = '{1'b1, 16'h0012, 11'h012, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[6]  = '{1'b1, 16'h0013, 11'h013, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[7]  = '{1'b0, 16'h0,    11'h0,   1'b1, 1'b0, 1'b0, 11'h0,   10'h03E, 4'h0};
    tbl[8]  = '{1'b1, 16'h0021, 11'h021, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[9]  = '{1'b1, 16'h0022, 11'h022, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h0};
    tbl[10] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h1};
    tbl[11] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b1, 1'b0, 11'h0,   10'h0,   4'h1};
    tbl[12] = '{1'b1, 16'h0062, 11'h062, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h1};
    tbl[13] = '{1'b1, 16'h0063, 11'h063, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h1};
    tbl[14] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h3};
    tbl[15] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'h7};
    tbl[16] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b1, 11'h030, 10'h0,   4'h7};
    tbl[17] = '{1'b0, 16'h0,    11'h0,   1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'hF};
    tbl[18] = '{1'b1, 16'h0027, 11'h027, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'hF};
    tbl[19] = '{1'b1, 16'h0030, 11'h030, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'hF};
    tbl[20] = '{1'b1, 16'h0031, 11'h031, 1'b0, 1'b0, 1'b0, 11'h0,   10'h0,   4'hF};

    for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;
    rom[11'h010] = 16'h1234; rom[11'h011] = 16'hD020; rom[11'h012] = 16'h0012;
    rom[11'h013] = 16'h0013; rom[11'h020] = 16'hF040; rom[11'h021] = 16'h0021;
    rom[11'h022] = 16'h0022; rom[11'h060] = 16'hF005; rom[11'h061] = 16'hE000;
    rom[11'h062] = 16'h0062; rom[11'h063] = 16'h0063; rom[11'h023] = 16'hE000;
    rom[11'h024] = 16'hF001; rom[11'h025] = 16'hD030; rom[11'h026] = 16'hD040;
    rom[11'h027] = 16'h0027; rom[11'h030] = 16'h0030; rom[11'h031] = 16'h0031;

    bus.boot_addr_sel = 1'b0;
    bus.boot_addr     = 11'h555;
    hold_reset();
    chk("reset outputs", dut_pk(), 64'h0);
    chk("reset regs", {16'h0, bus.ir, bus.ir_pc, bus.preload_addr, bus.relative_addr}, 64'h0);

    // directed program; boot selection changes after the boot edge must not matter
    reset = 1'b0;
    for (int c = 0; c < 21; c++) begin
      next_cycle();
      chk($sformatf("dir c%0d", c), dut_pk(), vec_pk(tbl[c]));
      if (c == 0) bus.boot_addr_sel = 1'b1;
    end

    // reset during the jsr pulse, then the boot sequence must repeat
    bus.boot_addr_sel = 1'b0;
    hold_reset();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      chk($sformatf("rerun c%0d", c), dut_pk(), vec_pk(tbl[c]));
    end
    #2 reset = 1'b1;
    #1 chk("async reset in jsr", dut_pk(), 64'h0);
    hold_reset();
    reset = 1'b0;
    next_cycle();
    chk("reboot preload", dut_pk(), vec_pk(tbl[0]));

    // random program against the instruction-level model
    hold_reset();
    for (int a = 0; a < 2048; a++) begin
      int r;
      r = $urandom_range(0, 9);
      w = 16'($urandom);
      if (r == 0) begin
        w[15:12] = 4'hF;
        if ($urandom_range(0, 3) == 0) w[9:0] = 10'($urandom_range(0, 1));
      end
      else if (r == 1) w[15:12] = 4'hE;
      else if (r == 2) w[15:12] = 4'hD;
      else             w[15:12] = 4'($urandom_range(0, 12));
      rom[a] = w;
    end
    bus.boot_addr_sel = 1'b1;
    bus.boot_addr     = 11'($urandom);
    m_pc = bus.boot_addr; m_tgt = 11'h0; m_retto = 11'h0;
    m_depth = 1'b0; m_pend = 1'b0; m_slots = 0; m_err = 4'h0;
    reset = 1'b0;
    next_cycle();
    chk("rnd boot preload", dut_pk(), pk(1'b0, 16'h0, 11'h0, 1'b0, 1'b0, 1'b1, m_pc, 10'h0, 4'h0));
    next_cycle();
    chk("rnd squash 1", dut_pk(), 64'h0);
    next_cycle();
    chk("rnd squash 2", dut_pk(), 64'h0);

    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      w = rom[m_pc]; op = w[15:12]; ctrl = (op >= 4'hD);
      ev = 1'b0; ej = 1'b0; er = 1'b0; ep = 1'b0; epa = 11'h0; era = 10'h0;
      taken = 1'b0; t = 11'h0;
      if (m_slots > 0) begin
        m_slots--;
        if (ctrl) m_err[3] = 1'b1;
        else      ev = 1'b1;
      end
      else if (!ctrl) ev = 1'b1;
      else if (op == 4'hD) begin
        ep = 1'b1; epa = w[10:0]; taken = 1'b1; t = w[10:0];
      end
      else if (op == 4'hF) begin
        if (m_depth)              m_err[0] = 1'b1;
        else if (w[9:0] < 10'd2)  m_err[2] = 1'b1;
        else begin
          ej = 1'b1; era = w[9:0] - 10'd2; m_depth = 1'b1;
          m_retto = m_pc + 11'd3; taken = 1'b1; t = m_pc + {1'b0, w[9:0]};
        end
      end
      else begin
        if (!m_depth) m_err[1] = 1'b1;
        else begin
          er = 1'b1; m_depth = 1'b0; taken = 1'b1; t = m_retto;
        end
      end
      chk($sformatf("rnd step %0d @%h", k, m_pc), dut_pk(),
          pk(ev, w, m_pc, ej, er, ep, epa, era, m_err));
      if (taken) begin
        m_slots = 2; m_pend = 1'b1; m_tgt = t; m_pc = m_pc + 11'd1;
      end
      else if (m_pend && m_slots == 0) begin
        m_pend = 1'b0; m_pc = m_tgt;
      end
      else m_pc = m_pc + 11'd1;
    end

    #2 reset = 1'b1;
    #1 chk("async reset after random", dut_pk(), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
